// File: rtl/pong_graph_animate.sv
// Pong object renderer and once-per-frame game animation (paddle, ball, serve FSM).
// Game state advances only on the frame tick at row 481, outside the visible area.
module pong_graph_animate #(
  parameter int unsigned PADDLE_H  = 72,
  parameter int unsigned PADDLE_V  = 4,
  parameter int unsigned BALL_SIZE = 8,
  parameter int unsigned BALL_V    = 2
) (
  input  logic       CLK_50MHZ,
  input  logic       RESET,
  input  logic       video_on,
  input  logic       p_tick,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic [1:0] btn,
  output logic [2:0] rgb,
  output logic       hit,
  output logic       miss
);

  localparam int unsigned WALL_L = 32;
  localparam int unsigned WALL_R = 35;
  localparam int unsigned PAD_L  = 600;
  localparam int unsigned PAD_R  = 603;
  localparam int unsigned X_MAX  = 639;
  localparam int unsigned Y_MAX  = 479;

  localparam logic [9:0] PAD_Y0  = 10'd204;
  localparam logic [9:0] BALL_X0 = 10'd320;
  localparam logic [9:0] BALL_Y0 = 10'd240;

  typedef enum logic [0:0] {StIdle, StPlay} state_e;

  state_e     state_q, state_d;
  logic [9:0] pad_q, pad_d;
  logic [9:0] bx_q, bx_d;
  logic [9:0] by_q, by_d;
  logic       dx_neg_q, dx_neg_d;
  logic       dy_neg_q, dy_neg_d;
  logic       hit_d, miss_d;
  logic       dx_neg_nxt, dy_neg_nxt;
  logic [2:0] rgb_d;

  logic        refr_tick;
  logic [10:0] px, py;
  logic [10:0] pad_top, pad_bot;
  logic [10:0] ball_l, ball_r, ball_t, ball_b;
  logic        wall_on, pad_on, ball_on;

  assign refr_tick = p_tick && (pixel_x == 10'd0) && (pixel_y == 10'd481);

  // 11-bit extents so adding the object size never wraps
  assign px      = {1'b0, pixel_x};
  assign py      = {1'b0, pixel_y};
  assign pad_top = {1'b0, pad_q};
  assign pad_bot = {1'b0, pad_q} + 11'(PADDLE_H - 1);
  assign ball_l  = {1'b0, bx_q};
  assign ball_r  = {1'b0, bx_q} + 11'(BALL_SIZE - 1);
  assign ball_t  = {1'b0, by_q};
  assign ball_b  = {1'b0, by_q} + 11'(BALL_SIZE - 1);

  always_comb begin
    pad_d = pad_q;
    if (refr_tick) begin
      if (btn == 2'b10 && pad_top > 11'(PADDLE_V)) begin
        pad_d = pad_q - 10'(PADDLE_V);
      end else if (btn == 2'b01 && pad_bot < 11'(Y_MAX - PADDLE_V)) begin
        pad_d = pad_q + 10'(PADDLE_V);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bx_d       = bx_q;
    by_d       = by_q;
    dx_neg_d   = dx_neg_q;
    dy_neg_d   = dy_neg_q;
    dx_neg_nxt = dx_neg_q;
    dy_neg_nxt = dy_neg_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (refr_tick && btn != 2'b00) begin
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (refr_tick) begin
          if (ball_l > 11'(X_MAX - BALL_SIZE)) begin
            miss_d   = 1'b1;
            state_d  = StIdle;
            bx_d     = BALL_X0;
            by_d     = BALL_Y0;
            dx_neg_d = 1'b0;
            dy_neg_d = 1'b0;
          end else begin
            if (ball_t <= 11'(BALL_V)) begin
              dy_neg_nxt = 1'b0;
            end else if (ball_b >= 11'(Y_MAX - BALL_V)) begin
              dy_neg_nxt = 1'b1;
            end
            if (ball_l <= 11'(WALL_R + BALL_V)) begin
              dx_neg_nxt = 1'b0;
            end
            if (!dx_neg_q && ball_r >= 11'(PAD_L - BALL_V) && ball_r <= 11'(PAD_R) &&
                ball_b >= pad_top && ball_t <= pad_bot) begin
              dx_neg_nxt = 1'b1;
              hit_d      = 1'b1;
            end
            dx_neg_d = dx_neg_nxt;
            dy_neg_d = dy_neg_nxt;
            bx_d     = dx_neg_nxt ? bx_q - 10'(BALL_V) : bx_q + 10'(BALL_V);
            by_d     = dy_neg_nxt ? by_q - 10'(BALL_V) : by_q + 10'(BALL_V);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign wall_on = (px >= 11'(WALL_L)) && (px <= 11'(WALL_R));
  assign pad_on  = (px >= 11'(PAD_L)) && (px <= 11'(PAD_R)) && (py >= pad_top) && (py <= pad_bot);
  assign ball_on = (state_q == StPlay) && (px >= ball_l) && (px <= ball_r) &&
                   (py >= ball_t) && (py <= ball_b);

  always_comb begin
    rgb_d = 3'b000;
    if (video_on) begin
      if (wall_on) begin
        rgb_d = 3'b001;
      end else if (pad_on) begin
        rgb_d = 3'b010;
      end else if (ball_on) begin
        rgb_d = 3'b100;
      end else begin
        rgb_d = 3'b110;
      end
    end
  end

  always_ff @(posedge CLK_50MHZ or posedge RESET) begin
    if (RESET) begin
      state_q  <= StIdle;
      pad_q    <= PAD_Y0;
      bx_q     <= BALL_X0;
      by_q     <= BALL_Y0;
      dx_neg_q <= 1'b0;
      dy_neg_q <= 1'b0;
      hit      <= 1'b0;
      miss     <= 1'b0;
      rgb      <= 3'b000;
    end else begin
      state_q  <= state_d;
      pad_q    <= pad_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      dx_neg_q <= dx_neg_d;
      dy_neg_q <= dy_neg_d;
      hit      <= hit_d;
      miss     <= miss_d;
      if (p_tick) begin
        rgb <= rgb_d;
      end
    end
  end

endmodule

// File: tb/tb_pong_graph_animate.sv
// Bench for pong_graph_animate: directed scenarios followed by randomized frames,
// checked against a game model that tracks positions as plain integers.
module tb_pong_graph_animate;

  logic       clk = 1'b0;
  logic       rst;
  logic       video_on;
  logic       p_tick;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic [1:0] btn;
  logic [2:0] rgb;
  logic       hit;
  logic       miss;

  pong_graph_animate dut (
    .CLK_50MHZ(clk),
    .RESET    (rst),
    .video_on (video_on),
    .p_tick   (p_tick),
    .pixel_x  (pixel_x),
    .pixel_y  (pixel_y),
    .btn      (btn),
    .rgb      (rgb),
    .hit      (hit),
    .miss     (miss)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int hits_seen = 0;
  int misses_seen = 0;

  // Reference game state: signed integer velocities, no hardware encoding
  int m_pad, m_bx, m_by, m_dx, m_dy;
  bit m_play;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pad  = 204;
    m_bx   = 320;
    m_by   = 240;
    m_dx   = 2;
    m_dy   = 2;
    m_play = 0;
  endtask

  function automatic int exp_rgb(int x, int y, bit von);
    if (!von) return 0;
    if (x >= 32 && x <= 35) return 1;
    if (x >= 600 && x <= 603 && y >= m_pad && y < m_pad + 72) return 2;
    if (m_play && x >= m_bx && x < m_bx + 8 && y >= m_by && y < m_by + 8) return 4;
    return 6;
  endfunction

  // Advance the model one frame; returns expected pulses
  task automatic model_step(input logic [1:0] b, output bit eh, output bit em);
    int ndx, ndy;
    eh = 0;
    em = 0;
    if (!m_play) begin
      if (b != 2'b00) m_play = 1;
    end else if (m_bx > 631) begin
      em     = 1;
      m_play = 0;
      m_bx   = 320;
      m_by   = 240;
      m_dx   = 2;
      m_dy   = 2;
    end else begin
      ndx = m_dx;
      ndy = m_dy;
      if (m_by <= 2) ndy = 2;
      else if (m_by + 7 >= 477) ndy = -2;
      if (m_bx <= 37) ndx = 2;
      if (m_dx > 0 && m_bx + 7 >= 598 && m_bx + 7 <= 603 &&
          m_by + 7 >= m_pad && m_by <= m_pad + 71) begin
        ndx = -2;
        eh  = 1;
      end
      m_dx = ndx;
      m_dy = ndy;
      m_bx = m_bx + ndx;
      m_by = m_by + ndy;
    end
    if (b == 2'b10 && m_pad > 4) m_pad = m_pad - 4;
    else if (b == 2'b01 && m_pad + 71 < 475) m_pad = m_pad + 4;
  endtask

  task automatic cyc(input logic pt, input int x, input int y, input logic von);
    p_tick   = pt;
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [1:0] b);
    bit eh, em;
    btn = b;
    model_step(b, eh, em);
    cyc(1'b1, 0, 481, 1'b0);
    check("hit", int'(hit), int'(eh));
    check("miss", int'(miss), int'(em));
    check("rgb_blank_row", int'(rgb), 0);
    if (hit) hits_seen++;
    if (miss) misses_seen++;
    cyc(1'b0, $urandom_range(0, 799), $urandom_range(0, 524), 1'b1);
    check("hit_width", int'(hit), 0);
    check("miss_width", int'(miss), 0);
  endtask

  task automatic probe(input string tag, input int x, input int y, input logic von,
                       input int exp);
    if (x == 0 && y == 481) x = 1;
    cyc(1'b1, x, y, von);
    check(tag, int'(rgb), exp);
    cyc(1'b0, $urandom_range(0, 799), $urandom_range(0, 524), ~von);
    check({tag, "_hold"}, int'(rgb), exp);
  endtask

  task automatic mprobe(input string tag, input int x, input int y, input logic von);
    if (x == 0 && y == 481) x = 1;
    probe(tag, x, y, von, exp_rgb(x, y, von));
  endtask

  task automatic pulse_reset();
    #4;
    rst = 1'b1;
    #1;
    check("rst_rgb", int'(rgb), 0);
    check("rst_hit", int'(hit), 0);
    check("rst_miss", int'(miss), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cyc(1'b0, 320, 240, 1'b1);
    check("rst_rgb_no_ptick", int'(rgb), 0);
  endtask

  initial begin
    logic [1:0] b;
    rst      = 1'b1;
    video_on = 1'b0;
    p_tick   = 1'b0;
    pixel_x  = '0;
    pixel_y  = '0;
    btn      = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rgb", int'(rgb), 0);
    check("reset_hit", int'(hit), 0);
    check("reset_miss", int'(miss), 0);
    rst = 1'b0;

    repeat (2) frame(2'b00);
    probe("idle_ball_hidden", 320, 240, 1'b1, 6);
    probe("wall", 33, 100, 1'b1, 1);
    probe("paddle_home", 601, 210, 1'b1, 2);
    probe("blank_x700", 700, 100, 1'b0, 0);

    repeat (60) frame(2'b10);
    probe("paddle_top_row", 601, 4, 1'b1, 2);
    mprobe("above_paddle", 601, 3, 1'b1);
    repeat (110) frame(2'b01);
    probe("paddle_bot_row", 601, 475, 1'b1, 2);
    mprobe("below_paddle", 601, 476, 1'b1);
    repeat (5) frame(2'b11);
    probe("both_btn_bot", 601, 475, 1'b1, 2);
    probe("both_btn_top", 601, 404, 1'b1, 2);
    mprobe("both_btn_above", 601, 403, 1'b1);

    pulse_reset();
    frame(2'b01);
    repeat (10) frame(2'b00);
    probe("ball_drawn", 341, 261, 1'b1, 4);
    probe("ball_left_edge", 339, 261, 1'b1, 6);
    probe("ball_right_edge", 348, 261, 1'b1, 6);
    probe("ball_last_col", 347, 267, 1'b1, 4);

    repeat (20) frame(2'b00);
    probe("pre_reset_bg", 100, 100, 1'b1, 6);
    pulse_reset();
    probe("post_reset_hidden", 320, 240, 1'b1, 6);
    probe("post_reset_paddle", 601, 204, 1'b1, 2);

    for (int f = 0; f < 2500; f++) begin
      if ((f / 150) % 2 == 0 && m_play) begin
        if (m_pad + 36 > m_by + 6) b = 2'b10;
        else if (m_pad + 36 < m_by + 2) b = 2'b01;
        else b = 2'b00;
      end else begin
        b = 2'($urandom_range(0, 3));
      end
      frame(b);
      mprobe("rnd_ball", m_bx + $urandom_range(0, 9) - 1, m_by + $urandom_range(0, 9) - 1,
             ($urandom_range(0, 7) != 0));
      mprobe("rnd_paddle", $urandom_range(598, 605), m_pad + $urandom_range(0, 75) - 2,
             ($urandom_range(0, 7) != 0));
      mprobe("rnd_any", $urandom_range(0, 799), $urandom_range(0, 524),
             ($urandom_range(0, 7) != 0));
    end
    check("saw_hit", int'(hits_seen > 0), 1);
    check("saw_miss", int'(misses_seen > 0), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pong_graph_animate.md
# pong_graph_animate

Pixel-generation and animation stage for the Pong game, directly downstream of the VGA sync generator. Consumes `pixel_x`, `pixel_y`, `video_on` and `p_tick` and produces the 3-bit colour for the current pixel. Once per frame it moves the paddle from the buttons and moves the ball, handling bounces, paddle hits and misses. A small serve FSM holds the ball hidden until the player presses a button.

## Interface
- `PADDLE_H`, 72: paddle height in pixels.
- `PADDLE_V`, 4: paddle step in pixels per frame.
- `BALL_SIZE`, 8: ball edge length in pixels (square ball).
- `BALL_V`, 2: ball step per axis in pixels per frame.

Ports:
- `CLK_50MHZ`  in  1  system clock, 50 MHz.
- `RESET`  in  1  reset, asynchronous, active-high.
- `video_on`  in  1  visible-area flag from the sync generator.
- `p_tick`  in  1  25 MHz pixel enable from the sync generator, high every other clock.
- `pixel_x`  in  10  current column, 0–799.
- `pixel_y`  in  10  current row, 0–524.
- `btn`  in  2  `btn[1]` = up, `btn[0]` = down. Synchronised and debounced upstream.
- `rgb`  out  3  pixel colour {R,G,B}, registered.
- `hit`  out  1  one-clock pulse when the ball bounces off the paddle.
- `miss`  out  1  one-clock pulse when the ball exits the right edge.

## Operation
- Frame tick: `refr_tick = p_tick && pixel_x==0 && pixel_y==481`. This is exactly one clock per frame. All game state updates only on `refr_tick`.
- Objects:
  - Wall: columns 32–35, full height.
  - Paddle: columns 600–603, rows `pad_y` to `pad_y+PADDLE_H-1`.
  - Ball: square with top-left corner at (`bx`, `by`).
- Paddle update:
  - Moves up by `PADDLE_V` when `btn==2'b10` and `pad_y > PADDLE_V`.
  - Moves down by `PADDLE_V` when `btn==2'b01` and `pad_y+PADDLE_H-1 < 479-PADDLE_V`.
  - Otherwise, including when both buttons are pressed, the paddle holds.
  - The paddle moves in both FSM states.
- Serve FSM, states IDLE and PLAY:
  - IDLE: ball hidden; `bx`=320, `by`=240, `dx`=+`BALL_V`, `dy`=+`BALL_V`. On `refr_tick` with `btn!=0`, go to PLAY; the ball position does not change on that tick.
  - PLAY, on `refr_tick`, rules evaluated in priority order:
    1. Miss: `bx > 639-BALL_SIZE`. Pulse `miss`, go to IDLE, reload the IDLE ball values. No further rules are applied.
    2. Otherwise compute the new deltas:
       - `dy`=+V if `by <= BALL_V`.
       - `dy`=−V if `by+BALL_SIZE-1 >= 479-BALL_V`.
       - `dx`=+V if `bx <= 35+BALL_V`.
       - Paddle hit: `dx`=−V and pulse `hit` when all hold: `dx`>0, `bx+BALL_SIZE-1` in [600−BALL_V, 603], and `by+BALL_SIZE-1 >= pad_y`, and `by <= pad_y+PADDLE_H-1`.
       - Any axis with no matching rule keeps its delta.
    3. Then `bx += dx_new`, `by += dy_new`.
- Arithmetic:
  - Positions are 10-bit unsigned.
  - Deltas are stored as a sign bit plus the magnitude `BALL_V`.
  - Comparisons use 11-bit sums, so `+SIZE` never wraps.
  - The bounce rules guarantee `by` stays in [1, 479−BALL_SIZE+1]. Position wrap-around must never occur.
- Colour priority, used when `video_on=1`:
  1. Wall → 3'b001.
  2. Paddle → 3'b010.
  3. Ball (PLAY only) → 3'b100.
  4. Background → 3'b110.
- When `video_on=0`, `rgb`=3'b000.

## Timing
- Reset values:
  - `rgb`=000, `hit`=0, `miss`=0.
  - State IDLE, `pad_y`=204.
  - `bx`=320, `by`=240, `dx`=+V, `dy`=+V.
- `rgb` register:
  - Loads only on clocks with `p_tick=1`, from that cycle's `pixel_x`/`pixel_y`/`video_on`. It then holds for 2 clocks.
  - Latency is 1 clock, matching the upstream registered sync outputs.
- Game-state registers, `hit` and `miss` change on the clock edge at which `refr_tick=1`.
- `hit` and `miss` are high for exactly one clock and are never high together.
- Game state changes outside the visible area (row 481), so no mid-frame tearing.
- `RESET` asserted mid-frame or mid-play: immediate return to the reset values. Play resumes from IDLE.

## Test plan
- Reset, run 2 frames with `btn=0` → state stays IDLE, `pad_y`=204. Pixel (320,240) is 110 (ball hidden), pixel (33,100) is 001, pixel (601,210) is 010, `rgb`=000 at x=700.
- `btn=2'b10` held for 60 frames → `pad_y` steps 204, 200, … and stops at 4. Hold `btn=2'b01` → it stops at 404 (bottom row 475). `btn=2'b11` → no movement.
- Press `btn` for one frame, then release → PLAY. After a further 10 frames, `bx`=340 and `by`=260. The ball square draws 100 at (341,261).
- Force `pad_y` to cover the ball's row and let the ball reach x≈592 → `hit` pulses for 1 clock, `dx` becomes −2, `bx` decreases. The ball later reaches `bx` ≤ 37 and returns with `dx`=+2, with no `hit` pulse.
- Paddle at `pad_y`=4, ball travelling low → `bx` exceeds 631 → `miss` pulses for 1 clock, state IDLE, ball reset to (320,240).
- Assert `RESET` for 1 clock mid-PLAY → all registers immediately return to the reset values, and `rgb`=000 until the next `p_tick`.
